mdu_iter: RTL

Iterative RV32M multiply/divide unit in the execute stage, downstream of the general-purpose register file. It consumes the two source operands read from the register file, computes one M-extension result over multiple cycles, and produces a single-cycle destination write (`rd_o`, `rd_data_o`, `rd_wen_o`) for the register file's write port. It uses a start/busy/done handshake so the pipeline stalls while an operation is in flight.

---
 rtl/mdu_iter.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle, registered rd write-back.
// Define MDU_DIV_EN to build the divider; without it divide ops return err_o.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            rd_wen_o
);

  localparam int W2 = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   rd_data_q, rd_data_d;
`ifdef MDU_DIV_EN
  logic              rem_neg_q, rem_neg_d;
`else
  logic              err_q, err_d;
`endif

  logic            sgn_a, sgn_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   mul_sum;
  logic [W2-1:0]   mul_step, acc_step, prod;
  logic [XLEN-1:0] mul_res, final_res;
`ifdef MDU_DIV_EN
  logic [XLEN:0]   div_part, div_diff;
  logic [W2-1:0]   div_step;
  logic [XLEN-1:0] quot, rem, div_res;
  logic            div_zero, div_ovf;
`endif

  // Operand signs and magnitudes for the op being requested.
  always_comb begin
    sgn_a = 1'b0;
    sgn_b = 1'b0;
`ifdef MDU_DIV_EN
    if (op_i[2]) begin
      sgn_a = ~op_i[0] & rs1_data_i[XLEN-1];
      sgn_b = ~op_i[0] & rs2_data_i[XLEN-1];
    end else begin
      sgn_a = (op_i[1:0] != 2'b11) & rs1_data_i[XLEN-1];
      sgn_b = ~op_i[1] & rs2_data_i[XLEN-1];
    end
    div_zero = (rs2_data_i == '0);
    div_ovf  = ~op_i[0] & (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_data_i);
`else
    sgn_a = (op_i[1:0] != 2'b11) & rs1_data_i[XLEN-1];
    sgn_b = ~op_i[1] & rs2_data_i[XLEN-1];
`endif
    mag_a = sgn_a ? -rs1_data_i : rs1_data_i;
    mag_b = sgn_b ? -rs2_data_i : rs2_data_i;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
    acc_step = mul_step;
`ifdef MDU_DIV_EN
    div_part = acc_q[W2-1:XLEN-1];
    div_diff = div_part - {1'b0, opnd_q};
    if (!div_diff[XLEN]) begin
      div_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_step = {div_part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
    if (op_q[2]) begin
      acc_step = div_step;
    end
`endif
  end

  // Sign fix-up applied to the accumulator produced by the last step.
  always_comb begin
    prod      = neg_q ? -acc_step : acc_step;
    mul_res   = (op_q == 3'b000) ? prod[XLEN-1:0] : prod[W2-1:XLEN];
    final_res = mul_res;
`ifdef MDU_DIV_EN
    quot    = acc_step[XLEN-1:0];
    rem     = acc_step[W2-1:XLEN];
    div_res = op_q[1] ? (rem_neg_q ? -rem : rem) : (neg_q ? -quot : quot);
    if (op_q[2]) begin
      final_res = div_res;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rd_d      = rd_q;
    rd_data_d = rd_data_q;
`ifdef MDU_DIV_EN
    rem_neg_d = rem_neg_q;
`else
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d  = op_i;
          rd_d  = rd_i;
          cnt_d = 5'd31;
          neg_d = sgn_a ^ sgn_b;
`ifdef MDU_DIV_EN
          rem_neg_d = sgn_a;
          if (op_i[2]) begin
            opnd_d = mag_b;
            acc_d  = {{XLEN{1'b0}}, mag_a};
            if (div_zero) begin
              rd_data_d = op_i[1] ? rs1_data_i : {XLEN{1'b1}};
              state_d   = S_DONE;
            end else if (div_ovf) begin
              rd_data_d = op_i[1] ? {XLEN{1'b0}} : rs1_data_i;
              state_d   = S_DONE;
            end else begin
              state_d = S_CALC;
            end
          end else begin
            opnd_d  = mag_a;
            acc_d   = {{XLEN{1'b0}}, mag_b};
            state_d = S_CALC;
          end
`else
          if (op_i[2]) begin
            err_d     = 1'b1;
            rd_data_d = '0;
            state_d   = S_DONE;
          end else begin
            err_d   = 1'b0;
            opnd_d  = mag_a;
            acc_d   = {{XLEN{1'b0}}, mag_b};
            state_d = S_CALC;
          end
`endif
        end
      end
      S_CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          rd_data_d = final_res;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rd_q      <= '0;
      rd_data_q <= '0;
`ifdef MDU_DIV_EN
      rem_neg_q <= 1'b0;
`else
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rd_q      <= rd_d;
      rd_data_q <= rd_data_d;
`ifdef MDU_DIV_EN
      rem_neg_q <= rem_neg_d;
`else
      err_q     <= err_d;
`endif
    end
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
`ifdef MDU_DIV_EN
  assign err_o     = 1'b0;
`else
  assign err_o     = done_o & err_q;
`endif
  assign rd_o      = rd_q;
  assign rd_data_o = rd_data_q;
  assign rd_wen_o  = done_o & ~err_o;

endmodule
